// File: rtl/uart_param.sv
// Parametrised UART: framed transmitter, 16x-oversampled receiver with
// parity/framing/overrun detection and a show-ahead RX FIFO.
module uart_param #(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                           clk_50m,
    input  logic                           rst_n,
    input  logic [DATA_BITS-1:0]           din,
    input  logic                           wr_en,
    output logic                           tx,
    output logic                           tx_busy,
    input  logic                           rx,
    output logic [DATA_BITS-1:0]           dout,
    output logic                           rdy,
    input  logic                           rd_en,
    output logic [$clog2(RX_FIFO_DEPTH):0] rx_level,
    output logic                           parity_err,
    output logic                           frame_err,
    output logic                           overrun,
    input  logic                           err_clr
);
    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int AW     = $clog2(RX_FIFO_DEPTH);
    localparam int TXC_W  = $clog2(TX_DIV) + 1;
    localparam int RXC_W  = $clog2(RX_DIV) + 1;
    localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(TX_DIV - 1);
    localparam logic [RXC_W-1:0] RX_LAST  = RXC_W'(RX_DIV - 1);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(RX_FIFO_DEPTH);
    localparam logic             HAS_PAR  = (PARITY != 32'sd0);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic p;
        case (PARITY)
            32'sd1:  p = ~(^d);
            32'sd2:  p = ^d;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    tx_state_t            tx_state_r, tx_state_s;
    logic [TXC_W-1:0]     tx_cnt_r;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic [2:0]           tx_bit_r, tx_bit_s;
    logic                 tx_par_r, tx_par_s;
    logic                 tx_tick_s, tx_line_s, tx_busy_s, tx_r, tx_busy_r;

    rx_state_t            rx_state_r, rx_state_s;
    logic                 rx_meta_r, rx_sync_r;
    logic [RXC_W-1:0]     rx_div_r;
    logic [3:0]           rx_cnt_r, rx_cnt_s;
    logic [2:0]           rx_bit_r, rx_bit_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic                 rx_par_r, rx_par_s, rx_tick_s;
    logic                 frame_done_s, frame_ev_s, parity_ev_s, push_req_s, overrun_ev_s;

    logic [DATA_BITS-1:0] mem_r [RX_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [AW:0]          level_r, level_s;
    logic                 full_s, push_s, pop_s, rdy_r;
    logic [DATA_BITS-1:0] head_s, dout_s, dout_r;
    logic                 parity_err_r, frame_err_r, overrun_r;

    assign tx_tick_s = (tx_cnt_r == TX_LAST);
    assign rx_tick_s = (rx_div_r == RX_LAST);

    // TX next-state, shift and registered line value
    always_comb begin
        tx_state_s = tx_state_r;
        tx_shift_s = tx_shift_r;
        tx_bit_s   = tx_bit_r;
        tx_par_s   = tx_par_r;
        tx_line_s  = 1'b1;
        case (tx_state_r)
            TX_IDLE: begin
                if (wr_en) begin
                    tx_state_s = TX_START;
                    tx_shift_s = din;
                    tx_par_s   = parity_of(din);
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_state_s = TX_DATA;
                    tx_bit_s   = 3'd0;
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s) begin
                    tx_shift_s = tx_shift_r >> 3'd1;
                    if (tx_bit_r == 3'(DATA_BITS - 1)) begin
                        tx_bit_s   = 3'd0;
                        tx_state_s = HAS_PAR ? TX_PAR : TX_STOP;
                    end else begin
                        tx_bit_s = tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_PAR: begin
                if (tx_tick_s) begin
                    tx_state_s = TX_STOP;
                end else begin
                    tx_state_s = TX_PAR;
                end
            end
            TX_STOP: begin
                if (tx_tick_s && (tx_bit_r == 3'(STOP_BITS - 1))) begin
                    // a write landing on the final stop tick starts the next frame back to back
                    if (wr_en) begin
                        tx_state_s = TX_START;
                        tx_shift_s = din;
                        tx_par_s   = parity_of(din);
                    end else begin
                        tx_state_s = TX_IDLE;
                    end
                    tx_bit_s = 3'd0;
                end else if (tx_tick_s) begin
                    tx_bit_s = tx_bit_r + 3'd1;
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: tx_state_s = TX_IDLE;
        endcase
        case (tx_state_s)
            TX_START: tx_line_s = 1'b0;
            TX_DATA:  tx_line_s = tx_shift_s[0];
            TX_PAR:   tx_line_s = tx_par_s;
            default:  tx_line_s = 1'b1;
        endcase
        tx_busy_s = (tx_state_s != TX_IDLE);
    end

    // TX state, baud counter and registered outputs
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_shift_r <= '0;
            tx_bit_r   <= 3'd0;
            tx_par_r   <= 1'b0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= ((tx_state_r == TX_IDLE) || tx_tick_s) ? '0 : tx_cnt_r + 1'b1;
            tx_shift_r <= tx_shift_s;
            tx_bit_r   <= tx_bit_s;
            tx_par_r   <= tx_par_s;
            tx_r       <= tx_line_s;
            tx_busy_r  <= tx_busy_s;
        end
    end

    // RX next-state and bit sampling; samples land 16 ticks apart from mid-start
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r;
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        rx_par_s     = rx_par_r;
        frame_done_s = 1'b0;
        if (rx_tick_s) begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (!rx_sync_r) begin
                        rx_state_s = RX_START;
                        rx_cnt_s   = 4'd0;
                    end else begin
                        rx_state_s = RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == 4'd7) begin
                        rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                        rx_cnt_s   = 4'd0;
                        rx_bit_s   = 3'd0;
                    end else begin
                        rx_cnt_s = rx_cnt_r + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == 4'd15) begin
                        rx_cnt_s   = 4'd0;
                        rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                        if (rx_bit_r == 3'(DATA_BITS - 1)) begin
                            rx_state_s = HAS_PAR ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_s = rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_s = rx_cnt_r + 4'd1;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt_r == 4'd15) begin
                        rx_cnt_s   = 4'd0;
                        rx_par_s   = rx_sync_r;
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_cnt_s = rx_cnt_r + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == 4'd15) begin
                        rx_cnt_s     = 4'd0;
                        rx_state_s   = RX_IDLE;
                        frame_done_s = 1'b1;
                    end else begin
                        rx_cnt_s = rx_cnt_r + 4'd1;
                    end
                end
                default: rx_state_s = RX_IDLE;
            endcase
        end else begin
            rx_state_s = rx_state_r;
        end
        frame_ev_s  = frame_done_s & ~rx_sync_r;
        parity_ev_s = frame_done_s & rx_sync_r & HAS_PAR & (rx_par_r != parity_of(rx_shift_r));
        push_req_s  = frame_done_s & rx_sync_r & ~parity_ev_s;
    end

    // RX synchroniser, oversample divider and FSM state
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_div_r   <= '0;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= '0;
            rx_par_r   <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_div_r   <= rx_tick_s ? '0 : rx_div_r + 1'b1;
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_par_r   <= rx_par_s;
        end
    end

    // FIFO control; head is pre-computed so dout is registered yet show-ahead
    always_comb begin
        full_s       = (level_r == FULL_LVL);
        pop_s        = rd_en & rdy_r;
        push_s       = push_req_s & (~full_s | pop_s);
        overrun_ev_s = push_req_s & full_s & ~pop_s;
        rd_ptr_s     = pop_s ? rd_ptr_r + 1'b1 : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + 1'b1;
            2'b01:   level_s = level_r - 1'b1;
            default: level_s = level_r;
        endcase
        head_s = (push_s && (wr_ptr_r == rd_ptr_s)) ? rx_shift_r : mem_r[rd_ptr_s];
        dout_s = (level_s == '0) ? '0 : head_s;
    end

    // FIFO storage
    always_ff @(posedge clk_50m) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_shift_r;
        end
    end

    // FIFO pointers, outputs and sticky error flags (a new event beats err_clr)
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            rdy_r        <= 1'b0;
            dout_r       <= '0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            wr_ptr_r     <= push_s ? wr_ptr_r + 1'b1 : wr_ptr_r;
            rd_ptr_r     <= rd_ptr_s;
            level_r      <= level_s;
            rdy_r        <= (level_s != '0);
            dout_r       <= dout_s;
            parity_err_r <= parity_ev_s  | (parity_err_r & ~err_clr);
            frame_err_r  <= frame_ev_s   | (frame_err_r & ~err_clr);
            overrun_r    <= overrun_ev_s | (overrun_r & ~err_clr);
        end
    end

    assign tx         = tx_r;
    assign tx_busy    = tx_busy_r;
    assign dout       = dout_r;
    assign rdy        = rdy_r;
    assign rx_level   = level_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1/depth-16 instance and a 7E2/depth-4 instance,
// both looped back, checked against frame and FIFO models built from plain arithmetic.
module tb_uart_param;
    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] din_a = 8'd0;
    logic       wr_en_a = 1'b0, rd_en_a = 1'b0, clr_a = 1'b0;
    logic       tx_a, busy_a, rdy_a, pe_a, fe_a, ov_a;
    logic [7:0] dout_a;
    logic [4:0] lvl_a;

    logic [6:0] din_b = 7'd0;
    logic       wr_en_b = 1'b0, rd_en_b = 1'b0, clr_b = 1'b0, inj_b = 1'b1;
    logic       tx_b, busy_b, rdy_b, pe_b, fe_b, ov_b, rx_b;
    logic [6:0] dout_b;
    logic [2:0] lvl_b;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    assign rx_b = tx_b & inj_b;

    always #10 clk_50m = ~clk_50m;

    uart_param #(.CLK_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .RX_FIFO_DEPTH(16)) dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din_a), .wr_en(wr_en_a), .tx(tx_a),
        .tx_busy(busy_a), .rx(tx_a), .dout(dout_a), .rdy(rdy_a), .rd_en(rd_en_a),
        .rx_level(lvl_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .err_clr(clr_a));

    uart_param #(.CLK_HZ(50000000), .BAUD(3125000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din_b), .wr_en(wr_en_b), .tx(tx_b),
        .tx_busy(busy_b), .rx(rx_b), .dout(dout_b), .rdy(rdy_b), .rd_en(rd_en_b),
        .rx_level(lvl_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .err_clr(clr_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int nbits, input int par, input int nstop);
        return 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
    endfunction

    // Line bits in time order: start, data LSB first, parity, stop bits
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int nbits, input int par);
        logic [15:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (par == 1) f[1+nbits] = ((ones % 2) == 0);
        if (par == 2) f[1+nbits] = ((ones % 2) == 1);
        return f;
    endfunction

    task automatic wait_idle(input bit use_b);
        int n = 0;
        while ((use_b ? busy_b : busy_a) && n < 1000) begin
            @(negedge clk_50m);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Transmit one byte in loopback, checking every bit centre and the busy window
    task automatic send(input bit use_b, input logic [7:0] d, input bit poke, input logic [7:0] d2);
        logic [15:0] f;
        int len, busy_cnt;
        logic t;
        len = use_b ? frame_len(7, 2, 2) : frame_len(8, 0, 1);
        f   = use_b ? frame_bits(d, 7, 2) : frame_bits(d, 8, 0);
        wait_idle(use_b);
        @(negedge clk_50m);
        if (use_b) begin din_b = d[6:0]; wr_en_b = 1'b1; end
        else begin din_a = d; wr_en_a = 1'b1; end
        @(posedge clk_50m);
        #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        busy_cnt = 0;
        for (int j = 0; j < len * 16 + 12; j++) begin
            @(negedge clk_50m);
            if (poke && j == 40) begin din_a = d2; din_b = d2[6:0]; wr_en_a = !use_b; wr_en_b = use_b; end
            if (poke && j == 41) begin wr_en_a = 1'b0; wr_en_b = 1'b0; end
            t = use_b ? tx_b : tx_a;
            if (use_b ? busy_b : busy_a) busy_cnt++;
            if (j < len * 16 && (j % 16) == 8) check($sformatf("tx_bit%0d", j / 16), t, f[j/16]);
            if (j == len * 16 + 8) check("tx_idle_line", t, 1'b1);
        end
        check("tx_busy_cycles", busy_cnt, len * 16);
        if (use_b) q_b.push_back({1'b0, d[6:0]});
        else q_a.push_back(d);
    endtask

    task automatic check_fifo(input bit use_b);
        @(negedge clk_50m);
        if (use_b) begin
            check("rdy_b", rdy_b, q_b.size() != 0);
            check("level_b", lvl_b, q_b.size());
            if (q_b.size() != 0) check("head_b", dout_b, q_b[0]);
        end else begin
            check("rdy_a", rdy_a, q_a.size() != 0);
            check("level_a", lvl_a, q_a.size());
            if (q_a.size() != 0) check("head_a", dout_a, q_a[0]);
        end
    endtask

    task automatic pop_check(input bit use_b);
        logic [7:0] e;
        @(negedge clk_50m);
        if (use_b) begin
            e = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
            check("pop_dout_b", dout_b, e);
            rd_en_b = 1'b1;
        end else begin
            e = (q_a.size() != 0) ? q_a.pop_front() : 8'hxx;
            check("pop_dout_a", dout_a, e);
            rd_en_a = 1'b1;
        end
        @(negedge clk_50m);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    // Drive a raw frame into instance B's rx; optionally pop at a chosen cycle,
    // and report when rx_level first moved and whether frame_err was ever seen high
    task automatic inject(input logic [15:0] f, input int len, input int pop_at,
                          output int meas, output logic saw_fe);
        int lvl0;
        lvl0 = int'(lvl_b);
        meas = -1;
        saw_fe = 1'b0;
        for (int idx = 1; idx <= len * 16 + 24; idx++) begin
            @(negedge clk_50m);
            if (meas < 0 && int'(lvl_b) != lvl0) meas = idx;
            if (fe_b) saw_fe = 1'b1;
            inj_b = (idx <= len * 16) ? f[(idx-1)/16] : 1'b1;
            rd_en_b = (idx == pop_at);
        end
        inj_b = 1'b1;
        rd_en_b = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_50m);
        clr_a = 1'b1;
        clr_b = 1'b1;
        @(negedge clk_50m);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    initial begin
        logic [15:0] f;
        logic [7:0]  d;
        int          m, m4;
        logic        saw;

        repeat (3) @(negedge clk_50m);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rdy", rdy_a, 1'b0);
        check("rst_level", lvl_a, 5'd0);
        check("rst_dout", dout_a, 8'd0);
        check("rst_flags", {pe_a, fe_a, ov_a, pe_b, fe_b, ov_b}, 6'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_50m);

        // 8N1 loopback: directed 0x55, then random bytes with two-deep FIFO use
        send(1'b0, 8'h55, 1'b0, 8'h00);
        check_fifo(1'b0);
        pop_check(1'b0);
        check_fifo(1'b0);
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            send(1'b0, d, 1'b0, 8'h00);
            check_fifo(1'b0);
            if (k % 2 == 1) begin
                pop_check(1'b0);
                pop_check(1'b0);
                check_fifo(1'b0);
            end
        end

        // 7E2 loopback and bad-parity injection
        send(1'b1, 8'h41, 1'b0, 8'h00);
        check_fifo(1'b1);
        pop_check(1'b1);
        f = frame_bits(8'h41, 7, 2);
        f[8] = ~f[8];
        inject(f, 10, -1, m, saw);
        check("parity_err_set", pe_b, 1'b1);
        check("parity_no_push", lvl_b, 3'd0);
        check("parity_no_frame_err", fe_b, 1'b0);
        pulse_clr();
        check("parity_err_clr", pe_b, 1'b0);

        // Framing error, clear, then error coinciding with err_clr
        f = frame_bits(8'h2a, 7, 2);
        f[9] = 1'b0;
        inject(f, 10, -1, m, saw);
        check("frame_err_set", fe_b, 1'b1);
        check("frame_no_push", lvl_b, 3'd0);
        pulse_clr();
        check("frame_err_clr", fe_b, 1'b0);
        @(negedge clk_50m);
        clr_b = 1'b1;
        inject(f, 10, -1, m, saw);
        clr_b = 1'b0;
        check("frame_err_set_wins", saw, 1'b1);

        // Overrun on a depth-4 FIFO, then drain in order
        for (int v = 1; v <= 5; v++) begin
            inject(frame_bits(8'(v), 7, 2), 10, -1, m, saw);
            if (q_b.size() < 4) q_b.push_back(8'(v));
        end
        check("ovr_level", lvl_b, 3'd4);
        check("ovr_flag", ov_b, 1'b1);
        check("ovr_head", dout_b, 7'h01);
        for (int k = 0; k < 4; k++) pop_check(1'b1);
        check_fifo(1'b1);
        pulse_clr();
        check("ovr_clr", ov_b, 1'b0);

        // Refill with random bytes, then push and pop on the same edge while full
        m4 = -1;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 127));
            inject(frame_bits(d, 7, 2), 10, -1, m, saw);
            q_b.push_back(d);
            m4 = m;
        end
        check("push_seen", m4 > 0, 1'b1);
        d = 8'($urandom_range(0, 127));
        inject(frame_bits(d, 7, 2), 10, m4 - 1, m, saw);
        void'(q_b.pop_front());
        q_b.push_back(d);
        check("full_pushpop_ovr", ov_b, 1'b0);
        check_fifo(1'b1);
        for (int k = 0; k < 4; k++) pop_check(1'b1);
        check_fifo(1'b1);

        // Short low pulse is rejected as a glitch
        @(negedge clk_50m);
        inj_b = 1'b0;
        repeat (4) @(negedge clk_50m);
        inj_b = 1'b1;
        repeat (40) @(negedge clk_50m);
        check("glitch_level", lvl_b, 3'd0);
        check("glitch_flags", {pe_b, fe_b, ov_b}, 3'd0);

        // Write while busy is ignored
        send(1'b0, 8'h3c, 1'b1, 8'hc5);
        repeat (200) @(negedge clk_50m);
        check("poke_busy", busy_a, 1'b0);
        check_fifo(1'b0);

        // Reset mid-frame (TX and RX both in data bits), then a fresh transfer
        wait_idle(1'b0);
        @(negedge clk_50m);
        din_a = 8'hc3;
        wr_en_a = 1'b1;
        @(posedge clk_50m);
        #1;
        wr_en_a = 1'b0;
        repeat (50) @(negedge clk_50m);
        check("pre_rst_rdy", rdy_a, 1'b1);
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx_a, 1'b1);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_rdy", rdy_a, 1'b0);
        check("midrst_level", lvl_a, 5'd0);
        q_a.delete();
        q_b.delete();
        @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50m);
        send(1'b0, 8'ha3, 1'b0, 8'h00);
        check_fifo(1'b0);
        pop_check(1'b0);
        check_fifo(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
